// File: rtl/hilo_pkg.sv
// Shared funct codes, FSM state type and op-decode helpers for the HI/LO multiply/divide unit.
package hilo_pkg;

   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_DIV   = 6'b011010;
   localparam logic [5:0] OP_DIVU  = 6'b011011;
   localparam logic [5:0] OP_MTHI  = 6'b010001;
   localparam logic [5:0] OP_MTLO  = 6'b010011;

   typedef enum logic [1:0] {IDLE, RUN, FIN} hilo_state_t;

   function automatic logic is_mul_op(input logic [5:0] op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   function automatic logic is_div_op(input logic [5:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [5:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned radix-2 datapath: shift-add multiply or restoring divide, one step per cycle,
// WIDTH steps after load.
module muldiv_iter_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               load,
   input  logic               is_div,
   input  logic [WIDTH-1:0]   a_mag,
   input  logic [WIDTH-1:0]   b_mag,
   output logic               step_done,
   output logic [2*WIDTH-1:0] prod,
   output logic [WIDTH-1:0]   quo,
   output logic [WIDTH-1:0]   rem
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] hi_q, lo_q, b_q;
   logic [CW-1:0]    cnt_q;
   logic             run_q, div_q;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic             div_ok;

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, b_q};
      // Shifted remainder is below 2*b, so a set MSB can only mean a borrow.
      div_ok    = ~div_diff[WIDTH];
      step_done = run_q && (cnt_q == CW'(WIDTH - 1));
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
         div_q <= 1'b0;
      end else if (load) begin
         hi_q  <= '0;
         lo_q  <= a_mag;
         b_q   <= b_mag;
         cnt_q <= '0;
         run_q <= 1'b1;
         div_q <= is_div;
      end else if (run_q) begin
         if (div_q) begin
            if (div_ok) begin
               hi_q <= div_diff[WIDTH-1:0];
               lo_q <= {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_q <= div_shift[WIDTH-1:0];
               lo_q <= {lo_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            hi_q <= mul_sum[WIDTH:1];
            lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
         end
         cnt_q <= step_done ? '0 : cnt_q + 1'b1;
         if (step_done) run_q <= 1'b0;
      end
   end

   assign prod = {hi_q, lo_q};
   assign quo  = lo_q;
   assign rem  = hi_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: accepts mult/div/mthi/mtlo via start/busy, runs the iterative core,
// applies sign fix-up and writes HI/LO with a one-cycle done pulse.
module hilo_muldiv_unit
   import hilo_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic [5:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   hilo_state_t      state_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             busy_q, done_q, dz_q;
   logic             div_q, neg_lo_q, neg_hi_q;

   logic               op_mul, op_div, op_signed;
   logic               a_neg, b_neg, b_zero, load;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               step_done;
   logic [2*WIDTH-1:0] prod, prod_neg;
   logic [WIDTH-1:0]   quo, rem;
   logic [WIDTH-1:0]   fin_hi, fin_lo;

   always_comb begin
      op_mul    = is_mul_op(op);
      op_div    = is_div_op(op);
      op_signed = is_signed_op(op);
      a_neg     = op_signed & A[WIDTH-1];
      b_neg     = op_signed & B[WIDTH-1];
      a_mag     = a_neg ? -A : A;
      b_mag     = b_neg ? -B : B;
      b_zero    = (B == '0);
      load      = (state_q == IDLE) && start && (op_mul || (op_div && !b_zero));
   end

   muldiv_iter_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .load      (load),
      .is_div    (op_div),
      .a_mag     (a_mag),
      .b_mag     (b_mag),
      .step_done (step_done),
      .prod      (prod),
      .quo       (quo),
      .rem       (rem)
   );

   // Most-negative / -1 needs no special case: the quotient magnitude negates onto itself.
   always_comb begin
      prod_neg = -prod;
      if (div_q) begin
         fin_lo = neg_lo_q ? -quo : quo;
         fin_hi = neg_hi_q ? -rem : rem;
      end else begin
         {fin_hi, fin_lo} = neg_lo_q ? prod_neg : prod;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
         div_q    <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  if (op == OP_MTHI) begin
                     hi_q <= A;
                  end else if (op == OP_MTLO) begin
                     lo_q <= A;
                  end else if (op_div && b_zero) begin
                     done_q <= 1'b1;
                     dz_q   <= 1'b1;
                  end else if (op_mul || op_div) begin
                     state_q  <= RUN;
                     busy_q   <= 1'b1;
                     div_q    <= op_div;
                     neg_lo_q <= a_neg ^ b_neg;
                     neg_hi_q <= op_div & a_neg;
                  end
               end
            end
            RUN: begin
               if (step_done) state_q <= FIN;
            end
            FIN: begin
               hi_q    <= fin_hi;
               lo_q    <= fin_lo;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;
   assign HI       = hi_q;
   assign LO       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed and randomized bench for hilo_muldiv_unit against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv_unit;

   localparam logic [5:0] C_MULT  = 6'b011000;
   localparam logic [5:0] C_MULTU = 6'b011001;
   localparam logic [5:0] C_DIV   = 6'b011010;
   localparam logic [5:0] C_DIVU  = 6'b011011;
   localparam logic [5:0] C_MTHI  = 6'b010001;
   localparam logic [5:0] C_MTLO  = 6'b010011;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  op = '0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        busy, done, div_zero;
   logic [31:0] HI, LO;

   int n_cmp = 0;
   int n_fail = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   hilo_muldiv_unit #(
      .WIDTH(32)
   ) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .start    (start),
      .op       (op),
      .A        (A),
      .B        (B),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .HI       (HI),
      .LO       (LO)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Architectural result of one op on the model's HI/LO.
   task automatic model(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p, q, r;
      logic [63:0] u;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         C_MULT: begin
            p = sa * sb;
            m_hi = p[63:32];
            m_lo = p[31:0];
         end
         C_MULTU: begin
            u = {32'b0, a} * {32'b0, b};
            m_hi = u[63:32];
            m_lo = u[31:0];
         end
         C_DIV: if (b != 0) begin
            q = sa / sb;
            r = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
         end
         C_DIVU: if (b != 0) begin
            m_lo = a / b;
            m_hi = a % b;
         end
         C_MTHI: m_hi = a;
         C_MTLO: m_lo = a;
         default: ;
      endcase
   endtask

   task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
      string tag;
      bit    md, got;
      int    n;
      tag = $sformatf("op=%b A=%h B=%h", o, a, b);
      md  = (o == C_MULT) || (o == C_MULTU) || (o == C_DIV) || (o == C_DIVU);
      @(negedge CLK);
      start = 1'b1;
      op    = o;
      A     = a;
      B     = b;
      @(posedge CLK);
      #1;
      start = 1'b0;
      op    = '0;
      model(o, a, b);
      if (!md) begin
         check({tag, " busy"}, 64'(busy), 64'd0);
         check({tag, " done"}, 64'(done), 64'd0);
         check({tag, " HI"}, 64'(HI), 64'(m_hi));
         check({tag, " LO"}, 64'(LO), 64'(m_lo));
      end else if ((o == C_DIV || o == C_DIVU) && b == 0) begin
         check({tag, " busy"}, 64'(busy), 64'd0);
         check({tag, " done"}, 64'(done), 64'd1);
         check({tag, " div_zero"}, 64'(div_zero), 64'd1);
         check({tag, " HI"}, 64'(HI), 64'(m_hi));
         check({tag, " LO"}, 64'(LO), 64'(m_lo));
         @(posedge CLK);
         #1;
         check({tag, " done clears"}, 64'(done), 64'd0);
         check({tag, " busy after"}, 64'(busy), 64'd0);
      end else begin
         check({tag, " busy"}, 64'(busy), 64'd1);
         got = 1'b0;
         n   = 0;
         while (!got && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
            if (poke && n == 5) begin
               start = 1'b1;
               op    = C_MTHI;
               A     = 32'hDEADBEEF;
            end else if (poke && n == 6) begin
               start = 1'b0;
               op    = '0;
            end
            if (done) got = 1'b1;
         end
         check({tag, " latency"}, 64'(n), 64'd33);
         check({tag, " busy at done"}, 64'(busy), 64'd0);
         check({tag, " div_zero"}, 64'(div_zero), 64'd0);
         check({tag, " HI"}, 64'(HI), 64'(m_hi));
         check({tag, " LO"}, 64'(LO), 64'(m_lo));
      end
   endtask

   initial begin
      logic [5:0]  ops [6];
      logic [31:0] ra, rb;
      logic [5:0]  ro;
      bit          saw;
      ops = '{C_MULT, C_MULTU, C_DIV, C_DIVU, C_MTHI, C_MTLO};

      #1;
      check("reset HI", 64'(HI), 64'd0);
      check("reset LO", 64'(LO), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      @(negedge CLK);
      RST_N = 1'b1;

      issue(C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      check("multu HI const", 64'(HI), 64'hFFFFFFFE);
      check("multu LO const", 64'(LO), 64'h00000001);

      issue(C_MULT, 32'hFFFFFFFD, 32'h00000007, 1'b0);
      check("mult HI const", 64'(HI), 64'hFFFFFFFF);
      check("mult LO const", 64'(LO), 64'hFFFFFFEB);
      issue(C_DIV, 32'hFFFFFFF9, 32'h00000002, 1'b0);
      check("div LO const", 64'(LO), 64'hFFFFFFFD);
      check("div HI const", 64'(HI), 64'hFFFFFFFF);

      issue(C_MTHI, 32'h12345678, 32'h0, 1'b0);
      issue(C_MTLO, 32'h12345678, 32'h0, 1'b0);
      issue(C_DIVU, 32'h0000000A, 32'h0, 1'b0);
      check("divu0 HI const", 64'(HI), 64'h12345678);

      issue(C_MULT, 32'h00001234, 32'h00005678, 1'b1);
      check("mthi while busy ignored", 64'(HI == 32'hDEADBEEF), 64'd0);
      issue(C_MTHI, 32'hDEADBEEF, 32'h0, 1'b0);
      check("mthi idle const", 64'(HI), 64'hDEADBEEF);

      // Second op issued during the first op's done cycle.
      issue(C_DIVU, 32'd100, 32'd7, 1'b0);
      issue(C_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      check("minneg div LO const", 64'(LO), 64'h80000000);
      check("minneg div HI const", 64'(HI), 64'h0);

      issue(6'b000000, 32'hCAFEF00D, 32'h1, 1'b0);
      issue(6'b011100, 32'h0BADF00D, 32'h2, 1'b0);

      for (int i = 0; i < 24; i++) begin
         ro = ops[$urandom_range(0, 5)];
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            2: rb = 32'($urandom_range(1, 15));
            3: ra = 32'($urandom_range(0, 100));
            default: ;
         endcase
         issue(ro, ra, rb, 1'b0);
      end

      // Reset in the middle of RUN discards the op.
      @(negedge CLK);
      start = 1'b1;
      op    = C_MULT;
      A     = 32'h7;
      B     = 32'h9;
      @(posedge CLK);
      #1;
      start = 1'b0;
      repeat (10) @(posedge CLK);
      #3;
      RST_N = 1'b0;
      #1;
      check("midrun reset HI", 64'(HI), 64'd0);
      check("midrun reset LO", 64'(LO), 64'd0);
      check("midrun reset busy", 64'(busy), 64'd0);
      check("midrun reset done", 64'(done), 64'd0);
      m_hi = '0;
      m_lo = '0;
      @(negedge CLK);
      RST_N = 1'b1;
      saw = 1'b0;
      repeat (40) begin
         @(posedge CLK);
         #1;
         if (done || busy) saw = 1'b1;
      end
      check("no activity after reset", 64'(saw), 64'd0);
      issue(C_DIVU, 32'd1000, 32'd33, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
